bch_dec_sec: RTL and testbench

- Pipelined BCH decoder for single-error-correcting codes (pErrorNum=1), with optional extended overall-parity bit (SEC-DED when pExtendOn=1).
- Receive-side counterpart of bch_enc: accepts codewords in the exact layout bch_enc produces, corrects any single-bit error, flags uncorrectable words, returns the data field.
- Sits after the storage or link that carries encoded words. Used as the golden decoder in the sim environment and as synthesizable RTL.

---
 rtl/bch_dec_sec.sv | 228 ++++++++++++++++++++++
 tb/tb_bch_dec_sec.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_sec.sv
// -----------------------------------------------------------------------------
// bch_dec_sec -- two-stage pipelined single-error-correcting BCH decoder
//
// Accepts codewords in the bch_enc layout, corrects any single-bit error,
// flags uncorrectable words and returns the data field. With pExtendOn=1 the
// extra overall even-parity bit (bit 0) gives SEC-DED behaviour.
//
// Codeword layout (m = pParityWidth):
//   i_code[pCodeWidth-1 -: pDataWidth] data, MSB = highest polynomial degree
//   next m bits                         data(x)*x^m mod g(x)
//   bit 0 (pExtendOn=1 only)            even parity over all other bits
//
// Ports:
//   clk              clock
//   rst_x            asynchronous active-low reset
//   i_enable         pipeline clock enable, every register holds when 0
//   i_code_valid     i_code valid this cycle
//   i_code           received codeword [pCodeWidth]
//   o_data_valid     o_data and status valid (2 enabled cycles after input)
//   o_data           corrected data (raw data field when uncorrectable)
//   o_corrected      exactly one bit error found and corrected
//   o_uncorrectable  detected error that cannot be corrected
//
// Optional feature, macro BCH_DEC_STATUS_CNT_EN:
//   i_cnt_clear      synchronous clear of both counters (wins over increment)
//   o_corr_cnt       saturating count of corrected output words
//   o_uncorr_cnt     saturating count of uncorrectable output words
// -----------------------------------------------------------------------------

package bch_dec_sec_pkg;

    // Smallest m with 2^m-1 >= k + m*t.
    function automatic int get_parity_width(input int k, input int t);
        int m;
        m = 0;
        for (int i = 16; i >= 1; i--) begin
            if (((2 ** i) - 1) >= (k + i * t)) m = i;
        end
        return m;
    endfunction

    function automatic int get_code_width(input int k, input int t, input int e);
        return k + get_parity_width(k, t) + e;
    endfunction

    // Primitive polynomial of degree m, bit i = coefficient of x^i.
    function automatic logic [31:0] get_prim_poly(input int m);
        case (m)
            3:       return 32'h0000_000B;
            4:       return 32'h0000_0013;
            5:       return 32'h0000_0025;
            6:       return 32'h0000_0043;
            7:       return 32'h0000_0089;
            8:       return 32'h0000_011D;
            9:       return 32'h0000_0211;
            10:      return 32'h0000_0409;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

module bch_dec_sec
    import bch_dec_sec_pkg::*;
#(
    parameter int pDataWidth   = 16,
    parameter int pErrorNum    = 1,
    parameter int pExtendOn    = 1,
    parameter int pParityWidth = get_parity_width(pDataWidth, pErrorNum),
    parameter int pCodeWidth   = get_code_width(pDataWidth, pErrorNum, pExtendOn)
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  i_enable,
    input  logic                  i_code_valid,
    input  logic [pCodeWidth-1:0] i_code,
`ifdef BCH_DEC_STATUS_CNT_EN
    input  logic                  i_cnt_clear,
    output logic [15:0]           o_corr_cnt,
    output logic [15:0]           o_uncorr_cnt,
`endif
    output logic                  o_data_valid,
    output logic [pDataWidth-1:0] o_data,
    output logic                  o_corrected,
    output logic                  o_uncorrectable
);

    localparam int M = pParityWidth;
    localparam int N = pDataWidth + M;   // polynomial positions, ext bit excluded

    generate
        if (pErrorNum != 1) begin : g_bad_error_num
            $error("bch_dec_sec supports pErrorNum=1 only");
        end
        if (get_prim_poly(M) == 32'h0) begin : g_bad_width
            $error("bch_dec_sec: no primitive polynomial for this pDataWidth");
        end
    endgenerate

    // alpha^j for j = 0..N-1, packed M bits per entry.
    function automatic logic [N*M-1:0] gen_alpha_tab();
        logic [N*M-1:0] tab;
        logic [M:0]     a;
        logic [31:0]    poly;
        poly = get_prim_poly(M);
        tab  = '0;
        a    = {{M{1'b0}}, 1'b1};
        for (int unsigned j = 0; j < N; j++) begin
            tab[j*M +: M] = a[M-1:0];
            a = a << 1;
            if (a[M]) a = a ^ poly[M:0];
        end
        return tab;
    endfunction

    localparam logic [N*M-1:0] ALPHA_TAB = gen_alpha_tab();

    // ---------------- stage 1: syndrome and overall parity ----------------
    logic [N-1:0]          poly_bits;
    logic [M-1:0]          s_d, s_q;
    logic                  p_d, p_q;
    logic [pDataWidth-1:0] raw_q;
    logic                  vld1_q;

    assign poly_bits = i_code[pCodeWidth-1 : pExtendOn];
    assign p_d       = (pExtendOn != 0) ? ^i_code : 1'b0;

    always_comb begin
        s_d = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (poly_bits[j]) s_d = s_d ^ ALPHA_TAB[j*M +: M];
        end
    end

    // Only the data field of the raw codeword is needed downstream.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            vld1_q <= 1'b0;
            s_q    <= '0;
            p_q    <= 1'b0;
            raw_q  <= '0;
        end else if (i_enable) begin
            vld1_q <= i_code_valid;
            if (i_code_valid) begin
                s_q   <= s_d;
                p_q   <= p_d;
                raw_q <= i_code[pCodeWidth-1 -: pDataWidth];
            end
        end
    end

    // ---------------- stage 2: locator and decision ----------------
    logic [N-1:0]          hit;
    logic                  match, s_nz, par_ok;
    logic [pDataWidth-1:0] data_d, data_q;
    logic                  corr_d, corr_q, unc_d, unc_q, vld2_q;

    always_comb begin
        hit = '0;
        for (int unsigned j = 0; j < N; j++) begin
            hit[j] = (s_q == ALPHA_TAB[j*M +: M]);
        end
    end

    assign match  = |hit;
    assign s_nz   = |s_q;
    // Without the ext bit p_q is always 0, so a located error needs no parity.
    assign par_ok = (pExtendOn != 0) ? p_q : 1'b1;

    always_comb begin
        data_d = raw_q;
        corr_d = 1'b0;
        unc_d  = 1'b0;
        if (vld1_q) begin
            if (s_nz && match && par_ok) begin
                corr_d = 1'b1;
                data_d = raw_q ^ hit[N-1:M];
            end else if (s_nz) begin
                unc_d = 1'b1;
            end else begin
                corr_d = p_q;   // error on the ext bit only
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            vld2_q <= 1'b0;
            data_q <= '0;
            corr_q <= 1'b0;
            unc_q  <= 1'b0;
        end else if (i_enable) begin
            vld2_q <= vld1_q;
            corr_q <= corr_d;
            unc_q  <= unc_d;
            if (vld1_q) data_q <= data_d;
        end
    end

    assign o_data_valid    = vld2_q;
    assign o_data          = data_q;
    assign o_corrected     = corr_q;
    assign o_uncorrectable = unc_q;

`ifdef BCH_DEC_STATUS_CNT_EN
    // ---------------- status counters ----------------
    logic [15:0] corr_cnt_q, unc_cnt_q;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else if (i_cnt_clear) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else if (i_enable && vld2_q) begin
            if (corr_q && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + 16'd1;
            if (unc_q  && (unc_cnt_q  != '1)) unc_cnt_q  <= unc_cnt_q  + 16'd1;
        end
    end

    assign o_corr_cnt   = corr_cnt_q;
    assign o_uncorr_cnt = unc_cnt_q;
`else
    // No status counters in this build.
`endif

endmodule

// File: tb/tb_bch_dec_sec.sv
module tb_bch_dec_sec;

    localparam int K  = 16;
    localparam int M  = 5;
    localparam int CW = 22;

    logic          clk;
    logic          rst_x;
    logic          i_enable;
    logic          i_code_valid;
    logic [CW-1:0] i_code;
    logic          o_data_valid;
    logic [K-1:0]  o_data;
    logic          o_corrected;
    logic          o_uncorrectable;
`ifdef BCH_DEC_STATUS_CNT_EN
    logic          i_cnt_clear;
    logic [15:0]   o_corr_cnt;
    logic [15:0]   o_uncorr_cnt;
`endif

    bch_dec_sec #(
        .pDataWidth (16),
        .pErrorNum  (1),
        .pExtendOn  (1)
    ) dut (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_enable        (i_enable),
        .i_code_valid    (i_code_valid),
        .i_code          (i_code),
`ifdef BCH_DEC_STATUS_CNT_EN
        .i_cnt_clear     (i_cnt_clear),
        .o_corr_cnt      (o_corr_cnt),
        .o_uncorr_cnt    (o_uncorr_cnt),
`endif
        .o_data_valid    (o_data_valid),
        .o_data          (o_data),
        .o_corrected     (o_corrected),
        .o_uncorrectable (o_uncorrectable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: GF(2) long division by g(x) = x^5+x^2+1.
    function automatic logic [CW-1:0] encode(input logic [K-1:0] d);
        logic [K+M-1:0] rem;
        logic [K+M-1:0] g;
        logic [K+M-1:0] c;
        g   = 'h25;
        rem = {d, 5'b0};
        for (int i = K + M - 1; i >= M; i--) begin
            if (rem[i]) rem = rem ^ (g << (i - M));
        end
        c = {d, rem[M-1:0]};
        return {c, ^c};
    endfunction

    typedef struct {
        logic [CW-1:0] code;
        logic [K-1:0]  data;
        logic          corr;
        logic          unc;
    } vec_t;

    typedef struct {
        logic [K-1:0] data;
        logic         corr;
        logic         unc;
    } exp_t;

    vec_t          vt[9];
    exp_t          sb[$];
    exp_t          e;
    logic [CW-1:0] base, rc;
    logic [K-1:0]  d;
    int            nf, p1, p2, sent, got;
    bit            en_prev, en, v;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_x        = 1'b0;
        i_enable     = 1'b0;
        i_code_valid = 1'b0;
        i_code       = '0;
`ifdef BCH_DEC_STATUS_CNT_EN
        i_cnt_clear  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, o_data_valid}, 32'd0);
        chk("rst_data", {16'b0, o_data}, 32'd0);
        chk("rst_flags", {30'b0, o_corrected, o_uncorrectable}, 32'd0);
        rst_x = 1'b1;

        // ---------------- directed vector table ----------------
        base  = encode(16'hA5C3);
        vt[0] = '{base,                                  16'hA5C3, 1'b0, 1'b0};
        vt[1] = '{base ^ (22'd1 << 14),                  16'hA5C3, 1'b1, 1'b0};
        vt[2] = '{base ^ (22'd1 << 3),                   16'hA5C3, 1'b1, 1'b0};
        vt[3] = '{base ^ (22'd1 << 0),                   16'hA5C3, 1'b1, 1'b0};
        // bits 20 and 7 are data bits 14 and 1: raw field A5C3 ^ 4002
        vt[4] = '{base ^ (22'd1 << 20) ^ (22'd1 << 7),   16'hE5C1, 1'b0, 1'b1};
        vt[5] = '{encode(16'h0000),                      16'h0000, 1'b0, 1'b0};
        vt[6] = '{encode(16'hFFFF) ^ (22'd1 << 21),      16'hFFFF, 1'b1, 1'b0};
        vt[7] = '{encode(16'h1234) ^ (22'd1 << 6),       16'h1234, 1'b1, 1'b0};
        vt[8] = '{encode(16'h1234) ^ (22'd1 << 1) ^ (22'd1 << 5), 16'h1234, 1'b0, 1'b1};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            i_enable = 1'b1; i_code_valid = 1'b1; i_code = vt[i].code;
            @(negedge clk);
            i_code_valid = 1'b0; i_code = '0;
            chk($sformatf("vec%0d_early", i), {31'b0, o_data_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {31'b0, o_data_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), {16'b0, o_data}, {16'b0, vt[i].data});
            chk($sformatf("vec%0d_corr", i), {31'b0, o_corrected}, {31'b0, vt[i].corr});
            chk($sformatf("vec%0d_unc", i), {31'b0, o_uncorrectable}, {31'b0, vt[i].unc});
        end
        repeat (2) @(negedge clk);

        // ---------------- random stream with enable toggling ----------------
        sent = 0; got = 0; en_prev = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            @(negedge clk);
            if (en_prev && o_data_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream_extra: unexpected output data=%0h", o_data);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("stream%0d_data", got), {16'b0, o_data}, {16'b0, e.data});
                    chk($sformatf("stream%0d_flags", got),
                        {30'b0, o_corrected, o_uncorrectable}, {30'b0, e.corr, e.unc});
                    got++;
                end
            end
            if (sent < 100) begin
                en = ($urandom_range(0, 3) != 0);
                v  = ($urandom_range(0, 3) != 0);
            end else begin
                en = 1'b1;
                v  = 1'b0;
            end
            i_enable     = en;
            i_code_valid = v;
            d  = K'($urandom);
            rc = encode(d);
            nf = $urandom_range(0, 2);
            p1 = $urandom_range(0, CW - 1);
            p2 = (p1 + 1 + $urandom_range(0, CW - 2)) % CW;
            if (nf >= 1) rc = rc ^ (22'd1 << p1);
            if (nf == 2) rc = rc ^ (22'd1 << p2);
            i_code = rc;
            if (en && v) begin
                e.data = (nf == 2) ? rc[CW-1:M+1] : d;
                e.corr = (nf == 1);
                e.unc  = (nf == 2);
                sb.push_back(e);
                sent++;
            end
            en_prev = en;
        end
        chk("stream_count", got, 32'd100);
        chk("stream_leftover", sb.size(), 32'd0);

        // ---------------- reset with two words in flight ----------------
        @(negedge clk);
        i_enable = 1'b1; i_code_valid = 1'b1; i_code = encode(16'h5A5A) ^ (22'd1 << 10);
        @(negedge clk);
        i_code = encode(16'h0F0F);
        @(negedge clk);
        i_code_valid = 1'b0; i_code = '0;
        chk("prerst_valid", {31'b0, o_data_valid}, 32'd1);
        chk("prerst_corr", {31'b0, o_corrected}, 32'd1);
        rst_x = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, o_data_valid}, 32'd0);
        chk("midrst_data", {16'b0, o_data}, 32'd0);
        chk("midrst_flags", {30'b0, o_corrected, o_uncorrectable}, 32'd0);
        @(negedge clk);
        rst_x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_stale", i), {31'b0, o_data_valid}, 32'd0);
        end
        i_code_valid = 1'b1; i_code = encode(16'h3C3C);
        @(negedge clk);
        i_code_valid = 1'b0; i_code = '0;
        chk("postrst_early", {31'b0, o_data_valid}, 32'd0);
        @(negedge clk);
        chk("postrst_valid", {31'b0, o_data_valid}, 32'd1);
        chk("postrst_data", {16'b0, o_data}, 32'h3C3C);
        repeat (2) @(negedge clk);

`ifdef BCH_DEC_STATUS_CNT_EN
        // ---------------- status counters ----------------
        i_cnt_clear = 1'b1;
        @(negedge clk);
        i_cnt_clear = 1'b0;
        chk("cnt_clr_corr", {16'b0, o_corr_cnt}, 32'd0);
        chk("cnt_clr_unc", {16'b0, o_uncorr_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            i_code_valid = 1'b1;
            i_code = (i < 3) ? (encode(16'h1111 * i) ^ (22'd1 << (i + 2)))
                             : (encode(16'h2222) ^ (22'd1 << 9) ^ (22'd1 << (i + 10)));
            @(negedge clk);
        end
        i_code_valid = 1'b0; i_code = '0;
        repeat (4) @(negedge clk);
        chk("cnt_corr3", {16'b0, o_corr_cnt}, 32'd3);
        chk("cnt_unc2", {16'b0, o_uncorr_cnt}, 32'd2);

        i_code_valid = 1'b1; i_code = encode(16'h7777) ^ (22'd1 << 12);
        @(negedge clk);
        i_code_valid = 1'b0; i_code = '0;
        @(negedge clk);
        chk("cnt_clrhit_corr_out", {31'b0, o_corrected}, 32'd1);
        i_cnt_clear = 1'b1;
        @(negedge clk);
        i_cnt_clear = 1'b0;
        chk("cnt_clrhit_corr", {16'b0, o_corr_cnt}, 32'd0);
        chk("cnt_clrhit_unc", {16'b0, o_uncorr_cnt}, 32'd0);
        @(negedge clk);
        chk("cnt_after_clr", {16'b0, o_corr_cnt}, 32'd0);

        i_code_valid = 1'b1; i_code = encode(16'hBEEF) ^ (22'd1 << 4);
        for (int i = 0; i < 65540; i++) @(negedge clk);
        i_code_valid = 1'b0; i_code = '0;
        repeat (4) @(negedge clk);
        chk("cnt_sat_corr", {16'b0, o_corr_cnt}, 32'h0000_FFFF);
        chk("cnt_sat_unc", {16'b0, o_uncorr_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
